booth_issuer: RTL
=================

# booth_issuer

Operand-issue and result-collection stage wrapped around the `Booth` sequential multiplier. It buffers incoming signed operand pairs in a small FIFO and issues them one at a time to `Booth`, producing a one-cycle `start` pulse with M/Q held stable. It waits for `valid` to rise, then presents the product, its operands and the measured latency on a valid/ready output port. This stage replaces bench-driven stimulus when `Booth` is embedded in a datapath.

## Interface
- `nb`, 8, operand width; the product is 2*nb bits.
- `DEPTH`, 4, operand FIFO depth; must be a power of two and at least 2.
- `CW`, 16, width of the latency counter.
- `TIMEOUT`, 1000, maximum WAIT cycles before an error completion; must be below 2^CW-1.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  FIFO can accept; equals !full.
- `in_m`, `in_q`  in  nb  signed operands.
- `mul_start`  out  1  to `Booth.start`.
- `mul_m`, `mul_q`  out  nb  to `Booth.M` and `Booth.Q`.
- `mul_valid`  in  1  from `Booth.valid`.
- `mul_o`  in  2*nb  from `Booth.O`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts.
- `out_m`, `out_q`  out  nb  operands of the reported result.
- `out_o`  out  2*nb  signed product.
- `out_cycles`  out  CW  cycles from the start pulse to completion, inclusive.
- `out_err`  out  1  completion was a timeout; `out_o` is 0.
- `fifo_count`  out  log2(DEPTH)+1  current FIFO occupancy.

## Operation
- FIFO push on `in_valid && in_ready`. Pop occurs only on the IDLE->START transition.
- When full, `in_ready`=0 with no same-cycle bypass, even if a pop occurs in that cycle. Simultaneous push and pop when not full leaves the count unchanged.
- FSM states and transitions:
  - IDLE: if `fifo_count`!=0, go to START. Load the FIFO head into `mul_m`/`mul_q`, pop, and clear the counter to 1.
  - START: `mul_start`=1 for exactly this one cycle. Increment the counter. Go to WAIT.
  - WAIT: increment the counter each cycle. On completion, capture `mul_o` and the counter value, then go to OUT.
  - OUT: `out_valid`=1. Hold all outputs until `out_ready`=1 at a clock edge, then go to IDLE.
- Completion is `mul_valid && !mul_valid_q`, where `mul_valid_q` is `mul_valid` registered every cycle. A valid level left high from the previous operation therefore cannot complete a new one.
- Timeout: if the counter reaches `TIMEOUT` while in WAIT, complete with `out_err`=1 and `out_o`=0. A later `mul_valid` edge in IDLE or OUT is ignored.
- `mul_m` and `mul_q` stay unchanged from the IDLE->START edge until the next IDLE->START edge.
- `out_m` and `out_q` are copies of the issued operands, captured at completion.
- Products are passed through unmodified; no arithmetic is performed on `mul_o`.

## Timing
- Reset value of every output is 0, with `in_ready`=1. Reset also empties the FIFO, sets the FSM to IDLE and clears the counter and `mul_valid_q`.
- A reset asserted mid-operation abandons the in-flight product and any queued operands; `mul_start` is low from reset assertion onward.
- Issue latency: a pair pushed at edge t into an empty FIFO with the FSM in IDLE gives `mul_start`=1 in the cycle after edge t+1.
- Completion latency: `out_valid` rises in the cycle after the edge that detects the `mul_valid` rising edge.
- `out_cycles` = (completion edge index) − (START edge index) + 1.
- There is a minimum of one IDLE cycle between `out_ready` acceptance and the next `mul_start`, so back-to-back operations cost Booth latency + 3 cycles.
- Throughput is one operation in flight; the FIFO absorbs bursts of up to DEPTH pairs.

## Structure
- `booth_pkg` holds the FSM state localparams (IDLE, START, WAIT, OUT; 2-bit encoding) and the default `TIMEOUT` value.
- Sub-module `booth_operand_fifo` (parameters nb, DEPTH) stores 2*nb-bit entries. It has push/pop/full/empty/count, wrap-around pointers with one extra bit, and the same `clk`/`rst`.
- The top level contains the FSM, counter, edge detector and output registers.

## Test plan
- Single op: push M=3, Q=-2 to a bench Booth model with valid 9 cycles after start -> one `mul_start` pulse, `out_o`=16'hFFFA, `out_cycles`=10, `out_err`=0.
- Burst: push 5 pairs back-to-back with DEPTH=4 and `out_ready`=0 -> `in_ready` drops when `fifo_count`=4. The fifth pair is accepted only after the first pop. Results come out in order.
- Output stall: hold `out_ready`=0 for 20 cycles after `out_valid` -> outputs stay stable, no new `mul_start`, and the FIFO count is unchanged by issue.
- Stale valid: the model keeps `valid` high from the previous op for 3 cycles after start -> no early completion, and the correct product is reported.
- Timeout: the model never raises `valid`, with TIMEOUT=50 -> `out_err`=1, `out_o`=0, `out_cycles`=50. The next queued op then issues normally.
- Reset mid-WAIT with 2 pairs queued -> all outputs 0, `fifo_count`=0, and no `mul_start` until a new push.

Source files
------------

// File: rtl/booth_pkg.sv
// booth_pkg: shared definitions for the Booth operand-issue stage.
//   state_t        - issue FSM state encoding (2 bits)
//   DefaultTimeout - default WAIT-cycle limit before an error completion
package booth_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StWait  = 2'd2,
        StOut   = 2'd3
    } state_t;

    localparam int unsigned DefaultTimeout = 1000;

endpackage

// File: rtl/booth_operand_fifo.sv
// booth_operand_fifo: operand-pair FIFO feeding the Booth issue FSM.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   push, wdata    - write request and {M, Q} entry (ignored when full)
//   pop, rdata     - read request and current head entry (ignored when empty)
//   full, empty    - occupancy flags
//   count          - current occupancy, 0..DEPTH
module booth_operand_fifo #(
    parameter int unsigned nb    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [2*nb-1:0]          wdata,
    input  logic                     pop,
    output logic [2*nb-1:0]          rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [AW:0]     wr_ptr_q;
    logic [AW:0]     rd_ptr_q;
    logic [2*nb-1:0] mem [DEPTH];
    logic            do_push;
    logic            do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is only read when the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/booth_issuer.sv
// booth_issuer: buffers signed operand pairs, issues them one at a time to a
// Booth sequential multiplier and reports each product with its latency.
// Ports:
//   clk, rst                   - clock, asynchronous active-high reset
//   in_valid/in_ready, in_m/q  - operand-pair input (in_ready = FIFO not full)
//   mul_start, mul_m, mul_q    - to Booth: one-cycle start, operands held stable
//   mul_valid, mul_o           - from Booth: done level and product
//   out_valid/out_ready        - result handshake
//   out_m, out_q, out_o        - issued operands and product (0 on timeout)
//   out_cycles                 - cycles from start pulse to completion, inclusive
//   out_err                    - completion was a timeout
//   fifo_count                 - current FIFO occupancy
module booth_issuer
    import booth_pkg::*;
#(
    parameter int unsigned nb      = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CW      = 16,
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [nb-1:0]          in_m,
    input  logic [nb-1:0]          in_q,
    output logic                   mul_start,
    output logic [nb-1:0]          mul_m,
    output logic [nb-1:0]          mul_q,
    input  logic                   mul_valid,
    input  logic [2*nb-1:0]        mul_o,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [nb-1:0]          out_m,
    output logic [nb-1:0]          out_q,
    output logic [2*nb-1:0]        out_o,
    output logic [CW-1:0]          out_cycles,
    output logic                   out_err,
    output logic [$clog2(DEPTH):0] fifo_count
);

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            mul_valid_q;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_pop;
    logic [2*nb-1:0] fifo_head;
    logic            mul_done;

    // No same-cycle bypass: a pop in a full cycle does not open in_ready.
    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign fifo_pop  = (state_q == StIdle) && !fifo_empty;

    // Only a fresh rising edge completes, so a valid level left over from the
    // previous operation cannot end the current one early.
    assign mul_done = mul_valid && !mul_valid_q;

    booth_operand_fifo #(
        .nb    (nb),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata ({in_m, in_q}),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mul_valid_q <= 1'b0;
            mul_start   <= 1'b0;
            mul_m       <= '0;
            mul_q       <= '0;
            out_valid   <= 1'b0;
            out_m       <= '0;
            out_q       <= '0;
            out_o       <= '0;
            out_cycles  <= '0;
            out_err     <= 1'b0;
        end else begin
            mul_valid_q <= mul_valid;
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        mul_m     <= fifo_head[2*nb-1:nb];
                        mul_q     <= fifo_head[nb-1:0];
                        cnt_q     <= CW'(1);
                        mul_start <= 1'b1;
                        state_q   <= StStart;
                    end
                end
                StStart: begin
                    mul_start <= 1'b0;
                    cnt_q     <= cnt_q + CW'(1);
                    state_q   <= StWait;
                end
                StWait: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (mul_done) begin
                        out_o      <= mul_o;
                        out_err    <= 1'b0;
                        out_m      <= mul_m;
                        out_q      <= mul_q;
                        out_cycles <= cnt_q;
                        out_valid  <= 1'b1;
                        state_q    <= StOut;
                    end else if (cnt_q == CW'(TIMEOUT)) begin
                        out_o      <= '0;
                        out_err    <= 1'b1;
                        out_m      <= mul_m;
                        out_q      <= mul_q;
                        out_cycles <= cnt_q;
                        out_valid  <= 1'b1;
                        state_q    <= StOut;
                    end
                end
                StOut: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
